// File: rtl/trigger_generator_if.sv
// trigger_generator_if
//   Bundles the control/config inputs and the trigger/status outputs of
//   trigger_generator. clk and rst stay plain module ports.
//   master : drives start, abort, trigger_width, trigger_gap, burst_count,
//            cycle_tick; observes trigger_out_p/_n, busy, done, trigger_index
//   slave  : the generator side (opposite directions)
interface trigger_generator_if #(
    parameter int INDEX_WIDTH = 8,
    parameter int WIDTH_BITS  = 10
);
    logic                   start;
    logic                   abort;
    logic [WIDTH_BITS-1:0]  trigger_width;
    logic [15:0]            trigger_gap;
    logic [7:0]             burst_count;
    logic                   cycle_tick;
    logic                   trigger_out_p;
    logic                   trigger_out_n;
    logic                   busy;
    logic                   done;
    logic [INDEX_WIDTH-1:0] trigger_index;

    modport master (
        output start, abort, trigger_width, trigger_gap, burst_count, cycle_tick,
        input  trigger_out_p, trigger_out_n, busy, done, trigger_index
    );

    modport slave (
        input  start, abort, trigger_width, trigger_gap, burst_count, cycle_tick,
        output trigger_out_p, trigger_out_n, busy, done, trigger_index
    );
endinterface

// File: rtl/trigger_generator.sv
// trigger_generator
//   Emits bursts of differential trigger pulses. A start in IDLE latches the
//   pulse width, gap and burst count; each pulse is preceded by WAIT_TICK and
//   pulses are separated by a low gap. trigger_index counts emitted pulses.
//   Optional macro TRIGGER_GEN_TICK_ALIGN_EN: when defined, each pulse waits
//   for cycle_tick and starts the cycle after it; when undefined, WAIT_TICK
//   lasts exactly one cycle and cycle_tick is ignored.
//
//   Ports: clk, rst (async, active high), bus (trigger_generator_if.slave)
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   IDLE      | no burst; waiting for start
//   WAIT_TICK | burst active, next pulse pending (alignment)
//   PULSE     | trigger_out_p high, width counter running
//   GAP       | trigger_out_p low between pulses
module trigger_generator #(
    parameter int INDEX_WIDTH = 8,
    parameter int WIDTH_BITS  = 10
) (
    input logic               clk,
    input logic               rst,
    trigger_generator_if.slave bus
);
    localparam int CNT_W = (WIDTH_BITS > 16) ? WIDTH_BITS : 16;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_TICK = 2'd1;
    localparam logic [1:0] S_PULSE     = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH_BITS-1:0]  width_q, width_d;
    logic [15:0]            gap_q, gap_d;
    logic [7:0]             left_q, left_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic                   out_p_q, out_p_d;
    logic                   done_q, done_d;

    logic [CNT_W-1:0]       width_load;
    logic [CNT_W-1:0]       gap_load;
    logic                   tick_ok;

`ifdef TRIGGER_GEN_TICK_ALIGN_EN
    assign tick_ok = bus.cycle_tick;
`else
    assign tick_ok = 1'b1;
`endif

    // Latched values are already clamped (width >= 1, gap >= 2).
    // GAP lasts gap-1 cycles; the mandatory WAIT_TICK cycle supplies the
    // last low cycle, so the low time between pulses is at least the gap.
    assign width_load = CNT_W'(width_q) - CNT_W'(1);
    assign gap_load   = CNT_W'(gap_q) - CNT_W'(2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        gap_d   = gap_q;
        left_d  = left_q;
        index_d = index_q;
        out_p_d = out_p_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
            out_p_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_p_d = 1'b0;
                    if (bus.start) begin
                        width_d = (bus.trigger_width == '0) ? WIDTH_BITS'(1) : bus.trigger_width;
                        gap_d   = (bus.trigger_gap < 16'd2) ? 16'd2 : bus.trigger_gap;
                        left_d  = (bus.burst_count == 8'd0) ? 8'd1 : bus.burst_count;
                        state_d = S_WAIT_TICK;
                    end
                end
                S_WAIT_TICK: begin
                    if (tick_ok) begin
                        state_d = S_PULSE;
                        out_p_d = 1'b1;
                        cnt_d   = width_load;
                        index_d = index_q + INDEX_WIDTH'(1);
                        // done marks the last high cycle of the final pulse
                        done_d  = (width_load == '0) && (left_q == 8'd1);
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        out_p_d = 1'b0;
                        if (left_q == 8'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            left_d  = left_q - 8'd1;
                            state_d = S_GAP;
                            cnt_d   = gap_load;
                        end
                    end else begin
                        cnt_d  = cnt_q - CNT_W'(1);
                        done_d = (cnt_q == CNT_W'(1)) && (left_q == 8'd1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = S_WAIT_TICK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    out_p_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            width_q <= '0;
            gap_q   <= '0;
            left_q  <= '0;
            index_q <= '0;
            out_p_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            left_q  <= left_d;
            index_q <= index_d;
            out_p_q <= out_p_d;
            done_q  <= done_d;
        end
    end

    assign bus.trigger_out_p = out_p_q;
    assign bus.trigger_out_n = ~out_p_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = done_q;
    assign bus.trigger_index = index_q;
endmodule

// File: tb/tb_trigger_generator.sv
`timescale 1ns/1ps
module tb_trigger_generator;
    localparam int MAXT = 512;
`ifdef TRIGGER_GEN_TICK_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [7:0] idx_model;

    trigger_generator_if #(.INDEX_WIDTH(8), .WIDTH_BITS(10)) bus ();
    trigger_generator #(.INDEX_WIDTH(8), .WIDTH_BITS(10)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // expected per-cycle trace of one burst (cycle 0 = first cycle after start edge)
    bit         exp_p    [MAXT];
    bit         exp_busy [MAXT];
    bit         exp_done [MAXT];
    bit         exp_rise [MAXT];
    logic [7:0] exp_idx  [MAXT];
    bit         tick_a   [MAXT];
    bit         sp_start [MAXT];

    typedef struct {
        int w; int g; int b; int abort_after;
        int pulses; int highs; int dones;
    } vec_t;
    vec_t vecs [7];

    task automatic chk_bit(input string name, input int t, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, t, act, exp);
        end
    endtask

    task automatic chk_idx(input string name, input int t, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, t, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.abort = 1'b0; bus.cycle_tick = 1'b0;
        bus.trigger_width = 10'd0; bus.trigger_gap = 16'd0; bus.burst_count = 8'd0;
    endtask

    // Timeline model: pulse k starts the cycle after the tick seen while the
    // burst is ready; ready again 'gap' cycles after the pulse's last high cycle.
    task automatic run_trial(input int w, input int g, input int b, input int per,
                             input int ph, input int ta_in, input bit noise);
        int ew, eg, eb, t_ready, tt, last, tend, ta;
        logic [7:0] cur;
        ew = (w == 0) ? 1 : w;
        eg = (g < 2) ? 2 : g;
        eb = (b == 0) ? 1 : b;
        for (int t = 0; t < MAXT; t++) begin
            tick_a[t] = ((t % per) == ph);
            exp_p[t] = 0; exp_busy[t] = 0; exp_done[t] = 0; exp_rise[t] = 0; sp_start[t] = 0;
        end
        t_ready = 0;
        last = 0;
        for (int k = 0; k < eb; k++) begin
            tt = t_ready;
            if (ALIGN) while (tt < MAXT - ew - 4 && !tick_a[tt]) tt++;
            exp_rise[tt + 1] = 1;
            for (int t = tt + 1; t <= tt + ew; t++) exp_p[t] = 1;
            last = tt + ew;
            t_ready = tt + ew + eg;
        end
        exp_done[last] = 1;
        cur = idx_model;
        for (int t = 0; t < MAXT; t++) begin
            if (exp_rise[t]) cur = cur + 8'd1;
            exp_idx[t] = cur;
            exp_busy[t] = (t <= last);
        end
        ta = (ta_in > last) ? -1 : ta_in;
        if (ta >= 0) begin
            for (int t = ta + 1; t < MAXT; t++) begin
                exp_p[t] = 0; exp_busy[t] = 0; exp_done[t] = 0; exp_idx[t] = exp_idx[ta];
            end
            tend = ta + 3;
        end else begin
            tend = last + 3;
        end
        if (noise)
            for (int t = 0; t <= tend; t++)
                sp_start[t] = exp_busy[t] && (ta < 0 || t <= ta) && ($urandom_range(0, 3) == 0);

        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b0; bus.cycle_tick = 1'b0;
        bus.trigger_width = 10'(w); bus.trigger_gap = 16'(g); bus.burst_count = 8'(b);
        for (int t = 0; t <= tend; t++) begin
            @(negedge clk);
            chk_bit("out_p", t, bus.trigger_out_p, exp_p[t]);
            chk_bit("out_n", t, bus.trigger_out_n, ~exp_p[t]);
            chk_bit("busy", t, bus.busy, exp_busy[t]);
            chk_bit("done", t, bus.done, exp_done[t]);
            chk_idx("index", t, bus.trigger_index, exp_idx[t]);
            bus.start = sp_start[t];
            bus.abort = (t == ta);
            bus.cycle_tick = tick_a[t];
            if (noise) begin
                bus.trigger_width = 10'($urandom);
                bus.trigger_gap = 16'($urandom);
                bus.burst_count = 8'($urandom);
            end
        end
        idle_inputs();
        idx_model = exp_idx[tend];
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int highs, pulses, dones;
        bit prev, fin;
        highs = 0; pulses = 0; dones = 0; prev = 0; fin = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b0; bus.cycle_tick = 1'b0;
        bus.trigger_width = 10'(v.w); bus.trigger_gap = 16'(v.g); bus.burst_count = 8'(v.b);
        for (int c = 0; c < 1500 && !fin; c++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.abort = 1'b0;
            if (bus.trigger_out_p) highs++;
            if (bus.trigger_out_p && !prev) pulses++;
            if (bus.done) dones++;
            if (v.abort_after > 0 && bus.trigger_out_p && highs == v.abort_after) bus.abort = 1'b1;
            if (!bus.busy) fin = 1;
            prev = bus.trigger_out_p;
            bus.cycle_tick = ((c % 100) == 20);
        end
        idle_inputs();
        chk_int($sformatf("vec%0d_finished", n), int'(fin), 1);
        chk_int($sformatf("vec%0d_pulses", n), pulses, v.pulses);
        chk_int($sformatf("vec%0d_high_cycles", n), highs, v.highs);
        chk_int($sformatf("vec%0d_dones", n), dones, v.dones);
        idx_model = idx_model + 8'(v.pulses);
        chk_idx($sformatf("vec%0d_index", n), 0, bus.trigger_index, idx_model);
        chk_bit($sformatf("vec%0d_out_low", n), 0, bus.trigger_out_p, 1'b0);
    endtask

    task automatic wait_p(input logic val, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.trigger_out_p === val) ok = 1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk_bit({tag, "_out_p"}, 0, bus.trigger_out_p, 1'b0);
        chk_bit({tag, "_out_n"}, 0, bus.trigger_out_n, 1'b1);
        chk_bit({tag, "_busy"}, 0, bus.busy, 1'b0);
        chk_bit({tag, "_done"}, 0, bus.done, 1'b0);
        chk_idx({tag, "_index"}, 0, bus.trigger_index, 8'd0);
    endtask

    initial begin
        bit ok;
        int per;
        vecs[0] = '{w:5,  g:10, b:3, abort_after:0, pulses:3, highs:15, dones:1};
        vecs[1] = '{w:0,  g:0,  b:0, abort_after:0, pulses:1, highs:1,  dones:1};
        vecs[2] = '{w:2,  g:1,  b:2, abort_after:0, pulses:2, highs:4,  dones:1};
        vecs[3] = '{w:10, g:3,  b:2, abort_after:3, pulses:1, highs:3,  dones:0};
        vecs[4] = '{w:1,  g:2,  b:4, abort_after:0, pulses:4, highs:4,  dones:1};
        vecs[5] = '{w:3,  g:0,  b:1, abort_after:0, pulses:1, highs:3,  dones:1};
        vecs[6] = '{w:4,  g:5,  b:3, abort_after:6, pulses:2, highs:6,  dones:0};

        idle_inputs();
        rst = 1'b1;
        idx_model = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // directed bursts with exact timeline
        run_trial(5, 10, 3, 100, 37, -1, 0);
        run_trial(0, 0, 0, 7, 3, -1, 0);
        run_trial(2, 1, 2, 4, 1, -1, 0);
        run_trial(10, 4, 2, 6, 2, 5, 0);

        // table-driven summaries
        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // abort has priority over start in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.burst_count = 8'd1;
        @(negedge clk);
        chk_bit("abort_over_start", 0, bus.busy, 1'b0);
        idle_inputs();

        // start during the done cycle is ignored, accepted one cycle later
        @(negedge clk);
        bus.start = 1'b1; bus.trigger_width = 10'd1; bus.burst_count = 8'd1; bus.cycle_tick = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.done) ok = 1;
        end
        chk_bit("done_seen", 0, ok, 1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        chk_bit("start_in_done_ignored", 0, bus.busy, 1'b0);
        @(negedge clk);
        chk_bit("start_after_done_taken", 0, bus.busy, 1'b1);
        bus.start = 1'b0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (!bus.busy) ok = 1;
        end
        chk_bit("second_burst_ends", 0, ok, 1'b1);
        idx_model = idx_model + 8'd2;
        chk_idx("index_after_done_restart", 0, bus.trigger_index, idx_model);
        idle_inputs();

        // randomized bursts against the timeline model
        for (int n = 0; n < 40; n++) begin
            per = $urandom_range(1, 8);
            run_trial($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 4),
                      per, $urandom_range(0, per - 1),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1, 1'b1);
        end

        // index wrap from 255 to 0
        for (int i = 0; i < 300 && idx_model != 8'hFF; i++) run_trial(0, 0, 0, 1, 0, -1, 0);
        chk_idx("index_at_255", 0, bus.trigger_index, 8'hFF);
        run_trial(1, 0, 1, 1, 0, -1, 0);
        chk_idx("index_wrap", 0, bus.trigger_index, 8'h00);

        // reset mid-pulse: output drops without waiting for a clock edge
        @(negedge clk);
        bus.start = 1'b1; bus.trigger_width = 10'd6; bus.trigger_gap = 16'd8;
        bus.burst_count = 8'd2; bus.cycle_tick = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_p(1'b1, ok);
        chk_bit("pulse_seen", 0, ok, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_values("rst_mid_pulse");
        @(negedge clk);
        rst = 1'b0;
        idx_model = 8'd0;

        // reset mid-gap, then a normal burst
        bus.start = 1'b1; bus.trigger_width = 10'd2; bus.trigger_gap = 16'd8; bus.burst_count = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_p(1'b1, ok);
        chk_bit("gap_pulse_rise", 0, ok, 1'b1);
        wait_p(1'b0, ok);
        chk_bit("gap_pulse_fall", 0, ok, 1'b1);
        @(negedge clk);
        chk_bit("in_gap_busy", 0, bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_values("rst_mid_gap");
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        idx_model = 8'd0;
        run_trial(3, 2, 2, 5, 1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trigger_generator.md
TRIGGER_GENERATOR -- requirements
Module: trigger_generator

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 8, width of trigger_index.
REQ-002 SHALL have parameter WIDTH_BITS, default 10, width of trigger_width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-006 SHALL have port abort  input  1  terminate any burst immediately.
REQ-007 SHALL have port trigger_width  input  WIDTH_BITS  pulse high time in clk cycles.
REQ-008 SHALL have port trigger_gap  input  16  low time between pulses in clk cycles.
REQ-009 SHALL have port burst_count  input  8  pulses per burst.
REQ-010 SHALL have port cycle_tick  input  1  alignment strobe, one cycle wide.
REQ-011 SHALL have port trigger_out_p  output  1  differential trigger, true leg.
REQ-012 SHALL have port trigger_out_n  output  1  differential trigger, complement leg.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle strobe at normal burst completion.
REQ-015 SHALL have port trigger_index  output  INDEX_WIDTH  count of pulses emitted.

Function
REQ-016 SHALL implement states IDLE, WAIT_TICK, PULSE, GAP.
REQ-017 SHALL, in IDLE with start=1, latch trigger_width, trigger_gap and burst_count, then go to WAIT_TICK; start SHALL be ignored outside IDLE.
REQ-018 SHALL treat latched width 0 as 1, burst_count 0 as 1, and gap values below 2 as 2, so a receiver's 3-stage edge detector always sees a low sample.
REQ-019 SHALL, in WAIT_TICK, go to PULSE in the cycle after cycle_tick=1.
REQ-020 SHALL drive trigger_out_p high for exactly the effective width, starting the first cycle in PULSE.
REQ-021 SHALL drive trigger_out_p from a register, with trigger_out_n its exact complement at all times.
REQ-022 SHALL increment trigger_index by 1 on entry to PULSE, wrapping all-ones to 0; start SHALL NOT clear it.
REQ-023 SHALL, at the end of a pulse with pulses remaining, go to GAP, hold output low for the effective gap, then go to WAIT_TICK.
REQ-024 SHALL, at the end of the final pulse, go directly to IDLE with no trailing gap, and pulse done=1 for that one cycle.
REQ-025 SHALL, on abort=1 in any state, go to IDLE the next cycle with trigger_out_p=0 and done=0; abort SHALL take priority over start and cycle_tick.
REQ-026 SHALL accept a start coinciding with the done cycle only on the following cycle, when state is IDLE.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, trigger_out_p=0, trigger_out_n=1, busy=0, done=0, trigger_index=0, and clear all internal counters.
REQ-028 SHALL, on rst asserted mid-pulse, drop trigger_out_p asynchronously with no glitch on the complement leg beyond the register transition.

Configuration
REQ-029 SHALL, with TRIGGER_GEN_TICK_ALIGN_EN defined, behave as in REQ-019.
REQ-030 SHALL, without TRIGGER_GEN_TICK_ALIGN_EN, pass through WAIT_TICK in one cycle ignoring cycle_tick, so the first pulse goes high 2 cycles after start and later pulses go high 1 cycle after GAP ends.

Verification
REQ-031 SHALL cover: macro on, width=5, gap=10, burst=3, tick every 100 cycles -> 3 pulses of 5 cycles, each starting 1 cycle after a tick; index 0->3; one done.
REQ-032 SHALL cover: width=0, burst=0, gap=0 -> single 1-cycle pulse, done once.
REQ-033 SHALL cover: abort on 3rd cycle of a 10-cycle pulse -> output low the next cycle, busy=0, no done, index already incremented.
REQ-034 SHALL cover: index at 255 plus one more pulse -> index 0.
REQ-035 SHALL cover: macro off, width=2, gap=1, burst=2 -> output high-high-low-low-high-high starting 2 cycles after start.
REQ-036 SHALL cover: rst asserted mid-GAP -> all outputs at reset values immediately, and a start after deassertion runs a normal burst.
